multi_channel_counter: RTL
==========================

Name: multi_channel_counter

Overview:
Parametrised successor to the single-channel stop-value counter.
- NUM_CH independent counters, each with its own terminal value, one-shot or periodic mode, and start/abort controls.
- A global count-enable gates all channels.
- Sits between the SST clock/reset driver and any model logic that needs multiple timers with done/tick status.

Parameters:
WIDTH, 64, counter and terminal-value width per channel
NUM_CH, 4, number of independent channels (>=1)

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
enable  in  1  global count enable; low freezes every RUN channel
start  in  NUM_CH  per-channel start/restart request, sampled at clk edge
abort  in  NUM_CH  per-channel cancel, sampled at clk edge
stop_val  in  NUM_CH*WIDTH  per-channel terminal count, channel i at [i*WIDTH +: WIDTH], captured on start
periodic  in  NUM_CH  per-channel mode, captured on start: 0 one-shot, 1 auto-reload
count  out  NUM_CH*WIDTH  current count per channel, same packing as stop_val
busy  out  NUM_CH  channel in RUN
done  out  NUM_CH  sticky, one-shot terminal reached; cleared by start/abort
tick  out  NUM_CH  one-cycle registered pulse on each terminal event
any_done  out  1  OR of done

Behaviour:
- Reset (async assert): all channels IDLE; count=0, busy=0, done=0, tick=0, captured limit=0, mode=0. Deassertion is assumed synchronous to clk by the environment.
- Per-channel FSM states: IDLE, RUN, DONE.
- IDLE: count holds 0. start -> RUN; count<=0, limit<=stop_val[i], mode<=periodic[i].
- RUN, enable=0: count, state and limit hold; tick=0.
- RUN, enable=1, count!=limit: count<=count+1; tick=0.
- RUN, enable=1, count==limit: tick<=1 for exactly one cycle.
  - mode=1: count<=0, stay RUN.
  - mode=0: -> DONE, done<=1, count holds at limit.
- DONE: count holds limit, done=1, busy=0. start -> RUN with a fresh capture, done<=0.
- Timing: start at edge E0 with enable held high -> tick and done visible after edge E0+stop_val+1. The periodic tick period is stop_val+1 cycles.
- stop_val=0: terminal on the first enabled edge after start.
- stop_val=all-ones: count reaches max and terminates. Increment never wraps, because the terminal check precedes the increment.
- Arithmetic is unsigned, WIDTH bits; comparison is full width.
- start in RUN: restart; count<=0, new limit and mode captured, no tick, even if count==limit that cycle.
- abort in any state: -> IDLE, count<=0, done<=0, tick<=0.
- abort and start in the same cycle: abort wins.
- Channels never interact, apart from sharing enable. Simultaneous events on different channels are independent.
- busy = (state==RUN). any_done is combinational from registered done.
- Reset mid-count: immediate return to IDLE values with no tick. A restart after reset requires a fresh start.

Decomposition:
- Package multi_channel_counter_pkg: typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} ch_state_t; mode constants MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1.
- Sub-module counter_channel (WIDTH param): one FSM, count, limit, mode, tick, done. Top instantiates NUM_CH copies in a generate loop and packs the vectors and any_done.

Test Plan:
- Reset asserted mid-RUN (ch0 count=5, stop_val=10) -> same-cycle outputs all 0; no tick after release; ch0 stays IDLE until start.
- ch0 one-shot, stop_val=3, enable=1, start at E0 -> count 0,1,2,3; tick and done high after E4; tick low after E5; done stays high; busy low from E4.
- ch1 periodic, stop_val=2 -> tick every 3 cycles for 4 periods; count sequence 0,1,2,0,1,2...; done never set.
- enable toggled low for 5 cycles during ch2 run (stop_val=4) -> count frozen; tick delayed exactly 5 cycles versus the continuous case.
- ch3 start and abort in the same cycle while RUN -> IDLE, count=0, no tick. Start with count==limit -> restart, no tick, new limit used.
- NUM_CH=4, WIDTH=8: stop_val=0 on ch0 (tick after E1) and 255 on ch1 (tick after E256, no wrap) started together -> independent ticks; any_done rises with ch0 done.

Source files
------------

// File: rtl/multi_channel_counter_pkg.sv
// -----------------------------------------------------------------------------
// multi_channel_counter_pkg
// Shared types and constants for the multi-channel stop-value counter.
//   ch_state_t     : per-channel FSM state (IDLE / RUN / DONE)
//   MODE_ONESHOT   : channel stops in DONE at its terminal value
//   MODE_PERIODIC  : channel reloads to zero at its terminal value
// -----------------------------------------------------------------------------
package multi_channel_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage : multi_channel_counter_pkg

// File: rtl/multi_channel_counter_channel.sv
// -----------------------------------------------------------------------------
// counter_channel
// One independent stop-value counter channel.
// Ports:
//   clk        : clock, all state on rising edge
//   reset      : asynchronous active-high reset
//   enable_i   : global count enable (freezes a running channel when low)
//   start_i    : start / restart request (captures stop_val_i and periodic_i)
//   abort_i    : cancel, returns to IDLE; wins over start_i
//   stop_val_i : terminal count captured on start
//   periodic_i : mode captured on start (0 one-shot, 1 auto-reload)
//   count_o    : current count
//   busy_o     : channel is in RUN
//   done_o     : sticky one-shot terminal flag
//   tick_o     : one-cycle pulse on each terminal event
// -----------------------------------------------------------------------------
module counter_channel
    import multi_channel_counter_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] stop_val_i,
    input  logic             periodic_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             tick_o
);

    ch_state_t        state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             mode_q,  mode_d;
    logic             tick_q,  tick_d;
    logic             done_q,  done_d;

    // Next-state logic: abort has top priority, then start, then the FSM.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        done_d  = done_q;

        if (abort_i) begin
            state_d = ST_IDLE;
            count_d = {WIDTH{1'b0}};
            done_d  = 1'b0;
        end else if (start_i) begin
            // Restart from any state; no tick even if count==limit this cycle.
            state_d = ST_RUN;
            count_d = {WIDTH{1'b0}};
            limit_d = stop_val_i;
            mode_d  = periodic_i;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    count_d = {WIDTH{1'b0}};
                end
                ST_RUN: begin
                    if (enable_i) begin
                        // Terminal check precedes the increment, so count never wraps.
                        if (count_q == limit_q) begin
                            tick_d = 1'b1;
                            if (mode_q == MODE_PERIODIC) begin
                                count_d = {WIDTH{1'b0}};
                            end else begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                ST_DONE: begin
                    count_d = count_q;
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = {WIDTH{1'b0}};
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= {WIDTH{1'b0}};
            limit_q <= {WIDTH{1'b0}};
            mode_q  <= MODE_ONESHOT;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign count_o = count_q;
    assign busy_o  = (state_q == ST_RUN);
    assign done_o  = done_q;
    assign tick_o  = tick_q;

endmodule : counter_channel

// File: rtl/multi_channel_counter.sv
// -----------------------------------------------------------------------------
// multi_channel_counter
// NUM_CH independent stop-value counters sharing a global count enable.
// Ports:
//   clk      : clock
//   reset    : asynchronous active-high reset
//   enable   : global count enable
//   start    : per-channel start/restart
//   abort    : per-channel cancel (wins over start)
//   stop_val : per-channel terminal count, channel i at [i*WIDTH +: WIDTH]
//   periodic : per-channel mode (0 one-shot, 1 auto-reload)
//   count    : per-channel count, same packing as stop_val
//   busy     : per-channel RUN indicator
//   done     : per-channel sticky one-shot done
//   tick     : per-channel terminal pulse
//   any_done : OR of done
// -----------------------------------------------------------------------------
module multi_channel_counter
    import multi_channel_counter_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int NUM_CH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       abort,
    input  logic [NUM_CH*WIDTH-1:0] stop_val,
    input  logic [NUM_CH-1:0]       periodic,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       tick,
    output logic                    any_done
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        counter_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .enable_i   (enable),
            .start_i    (start[g]),
            .abort_i    (abort[g]),
            .stop_val_i (stop_val[g*WIDTH +: WIDTH]),
            .periodic_i (periodic[g]),
            .count_o    (count[g*WIDTH +: WIDTH]),
            .busy_o     (busy[g]),
            .done_o     (done[g]),
            .tick_o     (tick[g])
        );
    end

    // Summary flag derived from the registered per-channel done bits.
    assign any_done = |done;

endmodule : multi_channel_counter
